// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: round-robin arbiter and sequencer that shares one registered 32-bit ALU
// between two requesters and returns each result over a valid/ready response channel.
module alu_issue_ctrl #(
  parameter bit          RR_INIT = 1'b0,  // requester holding priority after reset
  parameter int unsigned NUM_OPC = 10     // opcodes >= NUM_OPC are illegal
) (
  input  logic        CLK,
  input  logic        RST,        // active-low, synchronous

  // Requester 0
  input  logic        R0_REQ,
  input  logic [4:0]  R0_OPC,
  input  logic [31:0] R0_A,
  input  logic [31:0] R0_B,
  input  logic [4:0]  R0_SHFT,
  input  logic        R0_CIN,
  output logic        R0_GNT,

  // Requester 1
  input  logic        R1_REQ,
  input  logic [4:0]  R1_OPC,
  input  logic [31:0] R1_A,
  input  logic [31:0] R1_B,
  input  logic [4:0]  R1_SHFT,
  input  logic        R1_CIN,
  output logic        R1_GNT,

  // Response channel
  output logic        RSP_VALID,
  input  logic        RSP_RDY,
  output logic        RSP_ID,
  output logic [31:0] RSP_RSLT,
  output logic        RSP_ZR,
  output logic        RSP_NEG,
  output logic        RSP_COUT,
  output logic        RSP_OFLW,
  output logic        RSP_ERR,

  output logic        BUSY,

  // ALU interface
  output logic        ALU_EN,
  output logic [31:0] ALU_A,
  output logic [31:0] ALU_B,
  output logic [4:0]  ALU_OPC,
  output logic [4:0]  ALU_SHFT,
  output logic        ALU_CIN,
  input  logic [31:0] ALU_RSLT,
  input  logic        ALU_ZR,
  input  logic        ALU_NEG,
  input  logic        ALU_COUT,
  input  logic        ALU_OFLW
);

  localparam logic [4:0] OpcAdd = 5'd0;
  localparam logic [4:0] OpcSub = 5'd1;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StCapture = 2'd2,
    StResp    = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_ptr;

  logic   w_gnt0;
  logic   w_gnt1;
  logic   w_gnt_any;
  logic   w_win;

  logic [4:0]  w_sel_opc;
  logic [31:0] w_sel_a;
  logic [31:0] w_sel_b;
  logic [4:0]  w_sel_shft;
  logic        w_sel_cin;

  logic        r_alu_en;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [4:0]  r_alu_opc;
  logic [4:0]  r_alu_shft;
  logic        r_alu_cin;

  logic        r_rsp_valid;
  logic        r_rsp_id;
  logic [31:0] r_rsp_rslt;
  logic        r_rsp_zr;
  logic        r_rsp_neg;
  logic        r_rsp_cout;
  logic        r_rsp_oflw;
  logic        r_rsp_err;

  logic        w_is_add;
  logic        w_is_sub;
  logic        w_illegal;
  logic        w_sub_oflw;

  // Next-state decode and round-robin grant selection
  always_comb begin
    w_state_nxt = r_state;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_win       = r_ptr;
    unique case (r_state)
      StIdle: begin
        if (R0_REQ || R1_REQ) begin
          // A lone requester wins outright; a tie goes to the priority pointer
          if (R0_REQ && R1_REQ) begin
            w_win = r_ptr;
          end else begin
            w_win = R1_REQ;
          end
          w_gnt0      = ~w_win;
          w_gnt1      = w_win;
          w_state_nxt = StIssue;
        end
      end
      StIssue:   w_state_nxt = StCapture;
      StCapture: w_state_nxt = StResp;
      StResp: begin
        if (RSP_RDY) begin
          w_state_nxt = StIdle;
        end
      end
      default:   w_state_nxt = StIdle;
    endcase
    // No grant may escape while reset is held, since the edge will not honour it
    if (!RST) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  assign w_gnt_any = w_gnt0 | w_gnt1;

  // Operand mux from the winning requester
  always_comb begin
    w_sel_opc  = R0_OPC;
    w_sel_a    = R0_A;
    w_sel_b    = R0_B;
    w_sel_shft = R0_SHFT;
    w_sel_cin  = R0_CIN;
    if (w_win) begin
      w_sel_opc  = R1_OPC;
      w_sel_a    = R1_A;
      w_sel_b    = R1_B;
      w_sel_shft = R1_SHFT;
      w_sel_cin  = R1_CIN;
    end
  end

  // Flag qualification for the capture stage, using the operands still held on the ALU
  always_comb begin
    w_is_add   = (r_alu_opc == OpcAdd);
    w_is_sub   = (r_alu_opc == OpcSub);
    w_illegal  = (32'(r_alu_opc) >= NUM_OPC);
    // The ALU only reports add overflow, so subtract overflow is derived here
    w_sub_oflw = (r_alu_a[31] != r_alu_b[31]) & (ALU_RSLT[31] != r_alu_a[31]);
  end

  // State register and priority pointer
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= StIdle;
      r_ptr   <= RR_INIT;
    end else begin
      r_state <= w_state_nxt;
      if (w_gnt_any) begin
        r_ptr <= ~w_win;
      end
    end
  end

  // ALU drive registers: operands latched on grant and held until the next grant
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_alu_en   <= 1'b0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_opc  <= '0;
      r_alu_shft <= '0;
      r_alu_cin  <= 1'b0;
    end else begin
      // Enable is high exactly for the ISSUE cycle that follows a grant
      r_alu_en <= w_gnt_any;
      if (w_gnt_any) begin
        r_alu_a    <= w_sel_a;
        r_alu_b    <= w_sel_b;
        r_alu_opc  <= w_sel_opc;
        r_alu_shft <= w_sel_shft;
        r_alu_cin  <= w_sel_cin;
      end
    end
  end

  // Response registers: owner on grant, payload on capture, valid cleared on handshake
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_rslt  <= '0;
      r_rsp_zr    <= 1'b0;
      r_rsp_neg   <= 1'b0;
      r_rsp_cout  <= 1'b0;
      r_rsp_oflw  <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_gnt_any) begin
        r_rsp_id <= w_win;
      end
      if (r_state == StCapture) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rslt  <= ALU_RSLT;
        r_rsp_zr    <= ALU_ZR;
        r_rsp_neg   <= ALU_NEG;
        r_rsp_cout  <= (w_is_add | w_is_sub) & ALU_COUT;
        r_rsp_oflw  <= (w_is_add & ALU_OFLW) | (w_is_sub & w_sub_oflw);
        r_rsp_err   <= w_illegal;
      end else if ((r_state == StResp) && RSP_RDY) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign R0_GNT    = w_gnt0;
  assign R1_GNT    = w_gnt1;
  assign BUSY      = (r_state != StIdle);

  assign ALU_EN    = r_alu_en;
  assign ALU_A     = r_alu_a;
  assign ALU_B     = r_alu_b;
  assign ALU_OPC   = r_alu_opc;
  assign ALU_SHFT  = r_alu_shft;
  assign ALU_CIN   = r_alu_cin;

  assign RSP_VALID = r_rsp_valid;
  assign RSP_ID    = r_rsp_id;
  assign RSP_RSLT  = r_rsp_rslt;
  assign RSP_ZR    = r_rsp_zr;
  assign RSP_NEG   = r_rsp_neg;
  assign RSP_COUT  = r_rsp_cout;
  assign RSP_OFLW  = r_rsp_oflw;
  assign RSP_ERR   = r_rsp_err;

`ifndef SYNTHESIS
  // Grants are mutually exclusive and only ever issued from IDLE
  a_gnt_excl: assert property (@(posedge CLK) !(R0_GNT && R1_GNT));
  a_gnt_idle: assert property (@(posedge CLK) (R0_GNT || R1_GNT) |-> (r_state == StIdle));
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed and randomized check of alu_issue_ctrl with an ALU stand-in,
// a cycle-level grant/latency model and a response scoreboard.
module tb_alu_issue_ctrl;

  localparam bit          RR_INIT = 1'b0;
  localparam int unsigned NUM_OPC = 10;

  typedef struct packed {
    logic        id;
    logic [31:0] rslt;
    logic        zr;
    logic        neg;
    logic        cout;
    logic        oflw;
    logic        err;
  } rsp_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST;
  logic        req  [2];
  logic [4:0]  opc  [2];
  logic [31:0] a    [2];
  logic [31:0] b    [2];
  logic [4:0]  sh   [2];
  logic        cin  [2];
  logic        R0_GNT, R1_GNT;
  logic        RSP_VALID, RSP_RDY, RSP_ID;
  logic [31:0] RSP_RSLT;
  logic        RSP_ZR, RSP_NEG, RSP_COUT, RSP_OFLW, RSP_ERR;
  logic        BUSY, ALU_EN, ALU_CIN;
  logic [31:0] ALU_A, ALU_B;
  logic [4:0]  ALU_OPC, ALU_SHFT;
  logic [31:0] ALU_RSLT;
  logic        ALU_ZR, ALU_NEG, ALU_COUT, ALU_OFLW;

  rsp_t exp_q [$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   rand_done = 1'b0;

  alu_issue_ctrl #(.RR_INIT(RR_INIT), .NUM_OPC(NUM_OPC)) dut (
    .CLK(CLK), .RST(RST),
    .R0_REQ(req[0]), .R0_OPC(opc[0]), .R0_A(a[0]), .R0_B(b[0]), .R0_SHFT(sh[0]),
    .R0_CIN(cin[0]), .R0_GNT(R0_GNT),
    .R1_REQ(req[1]), .R1_OPC(opc[1]), .R1_A(a[1]), .R1_B(b[1]), .R1_SHFT(sh[1]),
    .R1_CIN(cin[1]), .R1_GNT(R1_GNT),
    .RSP_VALID(RSP_VALID), .RSP_RDY(RSP_RDY), .RSP_ID(RSP_ID), .RSP_RSLT(RSP_RSLT),
    .RSP_ZR(RSP_ZR), .RSP_NEG(RSP_NEG), .RSP_COUT(RSP_COUT), .RSP_OFLW(RSP_OFLW),
    .RSP_ERR(RSP_ERR), .BUSY(BUSY),
    .ALU_EN(ALU_EN), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_OPC(ALU_OPC), .ALU_SHFT(ALU_SHFT),
    .ALU_CIN(ALU_CIN), .ALU_RSLT(ALU_RSLT), .ALU_ZR(ALU_ZR), .ALU_NEG(ALU_NEG),
    .ALU_COUT(ALU_COUT), .ALU_OFLW(ALU_OFLW)
  );

  // ALU stand-in: registered result/flags, add-overflow combinational on its A/B inputs.
  // COUT reports the adder carry for every non-subtract op so masking is observable.
  function automatic logic [32:0] alu_fn(input logic [4:0] op, input logic [31:0] x,
                                         input logic [31:0] y, input logic [4:0] s,
                                         input logic c);
    logic [32:0] sum;
    logic [32:0] dif;
    logic [63:0] ext;
    sum = {1'b0, x} + {1'b0, y} + {32'b0, c};
    dif = {1'b0, x} - {1'b0, y} - {32'b0, c};
    ext = {{32{x[31]}}, x} >> s;
    case (op)
      5'd0:    return sum;
      5'd1:    return dif;
      5'd2:    return {sum[32], x & y};
      5'd3:    return {sum[32], x | y};
      5'd4:    return {sum[32], x ^ y};
      5'd5:    return {sum[32], x << s};
      5'd6:    return {sum[32], x >> s};
      5'd7:    return {sum[32], ext[31:0]};
      5'd8:    return {sum[32], 31'b0, (x[31] & ~y[31]) | (~(x[31] ^ y[31]) & dif[31])};
      5'd9:    return {sum[32], 31'b0, dif[32]};
      default: return {sum[32], 32'b0};
    endcase
  endfunction

  logic [32:0] alu_sum;
  logic [32:0] alu_res;
  assign alu_sum  = {1'b0, ALU_A} + {1'b0, ALU_B} + {32'b0, ALU_CIN};
  assign ALU_OFLW = (ALU_A[31] == ALU_B[31]) && (alu_sum[31] != ALU_A[31]);
  assign alu_res  = alu_fn(ALU_OPC, ALU_A, ALU_B, ALU_SHFT, ALU_CIN);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      ALU_RSLT <= '0;
      ALU_ZR   <= 1'b0;
      ALU_NEG  <= 1'b0;
      ALU_COUT <= 1'b0;
    end else if (ALU_EN) begin
      ALU_RSLT <= alu_res[31:0];
      ALU_ZR   <= (alu_res[31:0] == 32'b0);
      ALU_NEG  <= alu_res[31];
      ALU_COUT <= alu_res[32];
    end
  end

  // Reference: expected response straight from the opcode definitions
  function automatic rsp_t ref_rsp(input logic id, input logic [4:0] op, input logic [31:0] x,
                                   input logic [31:0] y, input logic [4:0] s, input logic c);
    rsp_t   e;
    longint wide;
    e    = '0;
    e.id = id;
    case (op)
      5'd0: begin
        wide   = longint'({32'b0, x}) + longint'({32'b0, y}) + longint'(c);
        e.rslt = x + y + {31'b0, c};
        e.cout = (wide > 64'h0000_0000_FFFF_FFFF);
        wide   = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
        e.oflw = (wide != longint'($signed(e.rslt)));
      end
      5'd1: begin
        e.rslt = x - y - {31'b0, c};
        e.cout = ({1'b0, x} < ({1'b0, y} + {32'b0, c}));
        e.oflw = (x[31] != y[31]) && (e.rslt[31] != x[31]);
      end
      5'd2:    e.rslt = x & y;
      5'd3:    e.rslt = x | y;
      5'd4:    e.rslt = x ^ y;
      5'd5:    e.rslt = x << s;
      5'd6:    e.rslt = x >> s;
      5'd7:    e.rslt = $signed(x) >>> s;
      5'd8:    e.rslt = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      5'd9:    e.rslt = (x < y) ? 32'd1 : 32'd0;
      default: e.err = 1'b1;
    endcase
    e.zr  = (e.rslt == 32'b0);
    e.neg = e.rslt[31];
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Grant/latency model: one op in flight, response due three cycles after its grant
  initial begin : model
    bit idle;
    bit ptr;
    bit gv;
    bit gid;
    int age;
    idle = 1'b1;
    ptr  = RR_INIT;
    age  = 0;
    forever begin
      @(negedge CLK);
      #2;
      gv  = 1'b0;
      gid = ptr;
      if (idle && RST === 1'b1 && (req[0] || req[1])) begin
        gv  = 1'b1;
        gid = (req[0] && req[1]) ? ptr : req[1];
      end
      chk("r0_gnt", 32'(R0_GNT), 32'(gv && !gid));
      chk("r1_gnt", 32'(R1_GNT), 32'(gv && gid));
      chk("busy", 32'(BUSY), 32'(!idle));
      chk("rsp_valid", 32'(RSP_VALID), 32'(!idle && age >= 3));
      if (gv) exp_q.push_back(ref_rsp(gid, opc[gid], a[gid], b[gid], sh[gid], cin[gid]));
      @(posedge CLK);
      if (RST !== 1'b1) begin
        idle = 1'b1;
        ptr  = RR_INIT;
        age  = 0;
        exp_q.delete();
      end else if (gv) begin
        idle = 1'b0;
        age  = 1;
        ptr  = ~gid;
      end else if (!idle) begin
        if (age >= 3) begin
          if (RSP_RDY) idle = 1'b1;
        end else begin
          age++;
        end
      end
    end
  end

  // Monitor: every cycle a response is presented it must match the oldest expectation
  initial begin : monitor
    rsp_t e;
    forever begin
      @(negedge CLK);
      #3;
      if (RSP_VALID === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_rsp: got id=%0d rslt=0x%08h, expected no response at %0t",
                   RSP_ID, RSP_RSLT, $time);
        end else begin
          e = exp_q[0];
          chk("rsp_id", 32'(RSP_ID), 32'(e.id));
          chk("rsp_rslt", RSP_RSLT, e.rslt);
          chk("rsp_zr", 32'(RSP_ZR), 32'(e.zr));
          chk("rsp_neg", 32'(RSP_NEG), 32'(e.neg));
          chk("rsp_cout", 32'(RSP_COUT), 32'(e.cout));
          chk("rsp_oflw", 32'(RSP_OFLW), 32'(e.oflw));
          chk("rsp_err", 32'(RSP_ERR), 32'(e.err));
          if (RSP_RDY && RST) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Present an op, hold it until granted, drop the request at the next negedge
  task automatic issue(input bit id, input logic [4:0] op, input logic [31:0] x,
                       input logic [31:0] y, input logic [4:0] s, input logic c);
    bit got;
    req[id] = 1'b1;
    opc[id] = op;
    a[id]   = x;
    b[id]   = y;
    sh[id]  = s;
    cin[id] = c;
    got     = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      #1;
      got = id ? R1_GNT : R0_GNT;
      if (!got) @(negedge CLK);
    end
    if (!got) begin
      n_vec++;
      n_bad++;
      $display("FAIL gnt_timeout: requester %0d got no grant, expected one within 300 cycles", id);
    end
    @(negedge CLK);
    req[id] = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge CLK);
      #4;
      done = !BUSY && (exp_q.size() == 0);
    end
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: busy=%0d pending=%0d, expected idle and empty", BUSY,
               exp_q.size());
    end
    @(negedge CLK);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'h0000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic drv(input bit id, input int n);
    logic [4:0] op;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      op = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(10, 31)) : 5'($urandom_range(0, 9));
      issue(id, op, rnd_opnd(), rnd_opnd(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : stim
    RST     = 1'b0;
    RSP_RDY = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0;
      opc[i] = '0;
      a[i]   = '0;
      b[i]   = '0;
      sh[i]  = '0;
      cin[i] = 1'b0;
    end
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_alu_en", 32'(ALU_EN), 32'd0);
    chk("rst_alu_a", ALU_A, 32'd0);
    chk("rst_alu_b", ALU_B, 32'd0);
    chk("rst_alu_opc", 32'(ALU_OPC), 32'd0);
    chk("rst_alu_shft", 32'(ALU_SHFT), 32'd0);
    chk("rst_alu_cin", 32'(ALU_CIN), 32'd0);
    chk("rst_rsp_rslt", RSP_RSLT, 32'd0);
    chk("rst_rsp_flags", 32'({RSP_ID, RSP_ZR, RSP_NEG, RSP_COUT, RSP_OFLW, RSP_ERR}), 32'd0);
    @(negedge CLK);
    RST = 1'b1;

    // Signed add overflow, then subtract overflow derived locally
    issue(1'b0, 5'd0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 1'b0);
    drain();
    issue(1'b1, 5'd1, 32'h8000_0000, 32'h0000_0001, 5'd0, 1'b0);
    drain();

    // Continuous contention: grants must alternate 0,1,0,1
    fork
      begin
        issue(1'b0, 5'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd3, 1'b0);
        issue(1'b0, 5'd4, 32'hAAAA_5555, 32'hFFFF_0000, 5'd1, 1'b1);
      end
      begin
        issue(1'b1, 5'd3, 32'h0000_00F0, 32'h1200_0000, 5'd7, 1'b1);
        issue(1'b1, 5'd8, 32'h8000_0000, 32'h0000_0001, 5'd2, 1'b0);
      end
    join
    drain();

    // Response stall with a competing illegal-opcode request waiting
    RSP_RDY = 1'b0;
    issue(1'b0, 5'd7, 32'hF000_0000, 32'h1234_5678, 5'd4, 1'b0);
    fork
      issue(1'b1, 5'h1F, 32'h1357_9BDF, 32'h2468_ACE0, 5'd9, 1'b1);
      begin
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
          @(negedge CLK);
          #1;
          seen = RSP_VALID;
        end
        if (!seen) begin
          n_vec++;
          n_bad++;
          $display("FAIL stall_valid_timeout: rsp_valid=0, expected 1 within 20 cycles");
        end
        repeat (5) @(negedge CLK);
        RSP_RDY = 1'b1;
      end
    join
    drain();

    // Reset while the op sits in CAPTURE: op dropped, pointer back to RR_INIT
    issue(1'b0, 5'd0, 32'h0000_0005, 32'h0000_0007, 5'd0, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    #1;
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_rsp_valid", 32'(RSP_VALID), 32'd0);
    chk("abort_alu_en", 32'(ALU_EN), 32'd0);
    chk("abort_alu_a", ALU_A, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    fork
      issue(1'b0, 5'd5, 32'h0000_0003, 32'h0, 5'd30, 1'b0);
      issue(1'b1, 5'd6, 32'h8000_0000, 32'h0, 5'd31, 1'b0);
    join
    drain();

    // Randomized traffic with random response back-pressure
    fork
      begin
        fork
          drv(1'b0, 40);
          drv(1'b1, 40);
        join
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge CLK);
          RSP_RDY = ($urandom_range(0, 3) != 0);
        end
      end
    join
    RSP_RDY = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Two-requester arbiter and sequencer for the shared 32-bit ALU. It accepts operation requests from two clients (R0, R1) and arbitrates them round-robin. It drives the ALU's operand/opcode/enable inputs, waits the ALU's one-cycle registered latency, and captures the result and flags. It then returns them to the winning client over a valid/ready response channel. It sits between the decode/issue stage and the ALU instance, and the ALU instance shares the same CLK and RST.

Parameters:
RR_INIT, 0, requester holding priority after reset (0 = R0, 1 = R1)
NUM_OPC, 10, number of legal opcodes; OPC >= NUM_OPC is illegal

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, active-low, synchronous
R0_REQ  in  1  R0 request valid
R0_OPC  in  5  R0 opcode (ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9)
R0_A, R0_B  in  32  R0 operands
R0_SHFT  in  5  R0 shift amount
R0_CIN  in  1  R0 carry/borrow in
R0_GNT  out  1  R0 request accepted this cycle (1-cycle pulse)
R1_REQ, R1_OPC, R1_A, R1_B, R1_SHFT, R1_CIN, R1_GNT  same as R0 for requester 1
RSP_VALID  out  1  response valid
RSP_RDY  in  1  response consumed
RSP_ID  out  1  requester owning the response
RSP_RSLT  out  32  result
RSP_ZR, RSP_NEG, RSP_COUT, RSP_OFLW  out  1  flags
RSP_ERR  out  1  opcode was illegal
BUSY  out  1  high in any state other than IDLE
ALU_EN  out  1  ALU enable, active-high
ALU_A, ALU_B  out  32  ALU operands
ALU_OPC  out  5  ALU opcode
ALU_SHFT  out  5  ALU shift amount
ALU_CIN  out  1  ALU carry in
ALU_RSLT  in  32  ALU result
ALU_ZR, ALU_NEG, ALU_COUT, ALU_OFLW  in  1  ALU flags

Behaviour:
- One clock (CLK). Reset is synchronous and active-low (RST). It takes priority over all other activity, including mid-operation.
- Reset values:
  - state = IDLE; priority pointer = RR_INIT.
  - All R*_GNT, RSP_*, BUSY and ALU_EN are 0.
  - ALU_A, ALU_B, ALU_OPC, ALU_SHFT and ALU_CIN are 0.
- A transaction in flight at reset is dropped silently; no response is issued.
- FSM states: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
- IDLE:
  - If any REQ is high, the winner is chosen: the only requester asserting REQ, or on a tie the one named by the priority pointer.
  - Winner's GNT pulses for this cycle. Its OPC/A/B/SHFT/CIN are latched into ALU_* registers, RSP_ID is latched, and the state goes to ISSUE.
  - Priority pointer is set to the non-winner.
  - With no REQ, the state stays in IDLE.
- ISSUE (1 cycle): ALU_EN=1; the ALU registers its result at the end of this cycle. Next state is CAPTURE.
- CAPTURE (1 cycle):
  - ALU_EN=0. ALU_A/ALU_B are held unchanged, because the ALU's OFLW output is combinational on its A/B inputs.
  - RSP_RSLT<=ALU_RSLT; RSP_ZR<=ALU_ZR; RSP_NEG<=ALU_NEG.
  - RSP_COUT<=ALU_COUT only for ADD/SUB, else 0.
  - RSP_OFLW:
    - ADD: ALU_OFLW.
    - SUB: computed locally as (A[31]!=B[31]) & (RSLT[31]!=A[31]).
    - Other opcodes: 0.
  - RSP_ERR<=1 if the latched OPC >= NUM_OPC (RSLT is then 0 from the ALU default).
  - RSP_VALID<=1; next state is RESP.
- RESP:
  - RSP_VALID and all RSP_* outputs stay stable until RSP_RDY=1 is sampled.
  - On that edge: RSP_VALID<=0 and the state goes to IDLE.
  - No new grant is issued in the RESP cycle.
- Latency: grant at cycle T gives RSP_VALID at T+3 (RSP_VALID becomes 1 at the edge ending T+2). Minimum occupancy is 4 cycles per op with RSP_RDY held high.
- Requests are level-sensitive. A requester keeps REQ/operands stable until it sees GNT. A REQ dropped before grant is simply not serviced.
- GNT is never asserted outside IDLE. Both GNTs are never high in the same cycle.
- Back-to-back: under continuous R0_REQ and R1_REQ, grants alternate R0, R1, R0, ... (starting per RR_INIT).
- BUSY = (state != IDLE).

Test Plan:
- Reset with RR_INIT=0, then R0 ADD A=0x7FFFFFFF, B=1, CIN=0 -> R0_GNT pulse; 3 cycles later RSP_VALID=1, RSP_ID=0, RSLT=0x80000000, OFLW=1, NEG=1, ZR=0, COUT=0.
- R1 SUB A=0x80000000, B=1 -> RSLT=0x7FFFFFFF, OFLW=1 (locally computed), NEG=0, ID=1.
- R0 and R1 both requesting continuously with RSP_RDY=1 for 4 ops -> grant order 0, 1, 0, 1; each response ID matches; no double grant.
- RSP_RDY held 0 for 5 cycles after RSP_VALID, on an R0 SRA A=0xF0000000, SHFT=4 -> RSLT=0xFF000000 stable for all stall cycles; no new GNT although R1_REQ=1; R1 granted the cycle after RSP_RDY is sampled.
- R1 OPC=5'b11111 -> RSP_ERR=1, RSLT=0, ZR=1, COUT=0, OFLW=0.
- RST=0 asserted in the CAPTURE state -> next cycle state is IDLE, RSP_VALID=0, ALU_EN=0, BUSY=0, pointer=RR_INIT; no response issued for the aborted op.
